// File: rtl/id_ex_stage_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
package id_ex_stage_reg_pkg;

    // Execute-stage command encodings. Zero is the no-op that flushed and
    // bubbled slots carry into EX.
    typedef enum logic [3:0] {
        ALU_NOP = 4'b0000,
        ALU_MOV = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_ADC = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SBC = 4'b0101,
        ALU_AND = 4'b0110,
        ALU_ORR = 4'b0111,
        ALU_EOR = 4'b1000,
        ALU_MVN = 4'b1001
    } alu_cmd_e;

    // What the register does on a clock edge, once reset has been ruled out.
    typedef enum logic [1:0] {
        MODE_LOAD   = 2'd0,
        MODE_BUBBLE = 2'd1,
        MODE_FLUSH  = 2'd2,
        MODE_FREEZE = 2'd3
    } stage_mode_e;

    // Bit positions of the NZCV status flags within sr.
    localparam int unsigned SR_V_BIT = 0;
    localparam int unsigned SR_C_BIT = 1;
    localparam int unsigned SR_Z_BIT = 2;
    localparam int unsigned SR_N_BIT = 3;

    // Control fields: everything a bubble must neutralise.
    typedef struct packed {
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       s;
        logic [3:0] alu_cmd;
        logic       valid;
    } id_ctrl_t;

    // Fixed-width operand fields. The DATA_W-wide PC and register values live
    // beside this bundle in the top because their width is a parameter.
    typedef struct packed {
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  sr;
    } id_fields_t;

    // Decode bundle: control plus operands.
    typedef struct packed {
        id_ctrl_t   ctrl;
        id_fields_t fields;
    } decode_bundle_t;

    // Resolves the per-edge priority freeze > flush > bubble > load.
    function automatic stage_mode_e select_mode(input logic freeze,
                                                input logic flush,
                                                input logic bubble);
        if (freeze)      return MODE_FREEZE;
        else if (flush)  return MODE_FLUSH;
        else if (bubble) return MODE_BUBBLE;
        else             return MODE_LOAD;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating event counter: counts inc pulses, holds when hold=1,
// sticks at all-ones, cleared only by synchronous reset.
module id_ex_stage_reg_sat_counter
    import id_ex_stage_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: step on inc unless held or already saturated.
    always_comb begin
        // NOTE: the default assignment comes first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (!hold && inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush, bubble insertion, freeze and
// saturating bubble/flush performance counters.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              bubble,
    input  logic              freeze,

    input  logic              wb_en_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              branch_in,
    input  logic              s_in,
    input  logic [3:0]        alu_cmd_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [3:0]        sr_in,
    input  logic              valid_in,

    output logic              wb_en_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              branch_out,
    output logic              s_out,
    output logic [3:0]        alu_cmd_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic [3:0]        sr_out,
    output logic              valid_out,

    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    decode_bundle_t    in_bundle;
    decode_bundle_t    bundle_q;
    decode_bundle_t    bundle_d;
    logic [DATA_W-1:0] pc_q,     pc_d;
    logic [DATA_W-1:0] val_rn_q, val_rn_d;
    logic [DATA_W-1:0] val_rm_q, val_rm_d;
    stage_mode_e       mode;
    logic              bubble_inc;
    logic              flush_inc;

    assign in_bundle.ctrl.wb_en                = wb_en_in;
    assign in_bundle.ctrl.mem_read             = mem_read_in;
    assign in_bundle.ctrl.mem_write            = mem_write_in;
    assign in_bundle.ctrl.branch               = branch_in;
    assign in_bundle.ctrl.s                    = s_in;
    assign in_bundle.ctrl.alu_cmd              = alu_cmd_in;
    assign in_bundle.ctrl.valid                = valid_in;
    assign in_bundle.fields.imm                = imm_in;
    assign in_bundle.fields.shift_operand      = shift_operand_in;
    assign in_bundle.fields.signed_imm24       = signed_imm24_in;
    assign in_bundle.fields.dest               = dest_in;
    assign in_bundle.fields.src1               = src1_in;
    assign in_bundle.fields.src2               = src2_in;
    assign in_bundle.fields.sr                 = sr_in;

    assign mode = select_mode(freeze, flush, bubble);

    // Next-state selection for every field according to the edge mode.
    always_comb begin
        bundle_d = bundle_q;
        pc_d     = pc_q;
        val_rn_d = val_rn_q;
        val_rm_d = val_rm_q;
        case (mode)
            MODE_FREEZE: begin
                // Hold everything; the requester re-asserts flush/bubble later.
            end
            MODE_FLUSH: begin
                bundle_d = '0;
                pc_d     = '0;
                val_rn_d = '0;
                val_rm_d = '0;
            end
            MODE_BUBBLE: begin
                // Operands still flow so the squashed slot remains readable.
                bundle_d      = in_bundle;
                bundle_d.ctrl = '0;
                pc_d          = pc_in;
                val_rn_d      = val_rn_in;
                val_rm_d      = val_rm_in;
            end
            default: begin
                // Control is qualified by valid_in so a slot that is not a real
                // instruction never carries write/memory/branch side effects.
                bundle_d = in_bundle;
                if (!valid_in) bundle_d.ctrl = '0;
                pc_d     = pc_in;
                val_rn_d = val_rn_in;
                val_rm_d = val_rm_in;
            end
        endcase
    end

    // Pipeline register; reset leaves a no-op in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q <= '0;
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
        end else begin
            bundle_q <= bundle_d;
            pc_q     <= pc_d;
            val_rn_q <= val_rn_d;
            val_rm_q <= val_rm_d;
        end
    end

    // Only a flush that squashes a real instruction is counted.
    assign bubble_inc = (mode == MODE_BUBBLE);
    assign flush_inc  = (mode == MODE_FLUSH) && valid_in;

    id_ex_stage_reg_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .hold  (freeze),
        .count (bubble_cnt)
    );

    id_ex_stage_reg_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .hold  (freeze),
        .count (flush_cnt)
    );

    assign wb_en_out         = bundle_q.ctrl.wb_en;
    assign mem_read_out      = bundle_q.ctrl.mem_read;
    assign mem_write_out     = bundle_q.ctrl.mem_write;
    assign branch_out        = bundle_q.ctrl.branch;
    assign s_out             = bundle_q.ctrl.s;
    assign alu_cmd_out       = bundle_q.ctrl.alu_cmd;
    assign valid_out         = bundle_q.ctrl.valid;
    assign imm_out           = bundle_q.fields.imm;
    assign shift_operand_out = bundle_q.fields.shift_operand;
    assign signed_imm24_out  = bundle_q.fields.signed_imm24;
    assign dest_out          = bundle_q.fields.dest;
    assign src1_out          = bundle_q.fields.src1;
    assign src2_out          = bundle_q.fields.src2;
    assign sr_out            = bundle_q.fields.sr;
    assign pc_out            = pc_q;
    assign val_rn_out        = val_rn_q;
    assign val_rm_out        = val_rm_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg (CNT_W=3 so saturation is reachable).
module tb_id_ex_stage_reg;
    import id_ex_stage_reg_pkg::*;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    logic rst, flush, bubble, freeze;
    logic wb_en_in, mem_read_in, mem_write_in, branch_in, s_in;
    logic [3:0] alu_cmd_in;
    logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in;
    logic imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm24_in;
    logic [3:0] dest_in, src1_in, src2_in, sr_in;
    logic valid_in;

    logic wb_en_out, mem_read_out, mem_write_out, branch_out, s_out;
    logic [3:0] alu_cmd_out;
    logic [DATA_W-1:0] pc_out, val_rn_out, val_rm_out;
    logic imm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm24_out;
    logic [3:0] dest_out, src1_out, src2_out, sr_out;
    logic valid_out;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    logic [158:0] all_out;
    assign all_out = {wb_en_out, mem_read_out, mem_write_out, branch_out, s_out,
                      alu_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
                      shift_operand_out, signed_imm24_out, dest_out, src1_out,
                      src2_out, sr_out, valid_out};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bubble(bubble), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .branch_in(branch_in), .s_in(s_in), .alu_cmd_in(alu_cmd_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
        .valid_in(valid_in),
        .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .branch_out(branch_out), .s_out(s_out), .alu_cmd_out(alu_cmd_out), .pc_out(pc_out),
        .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .sr_out(sr_out),
        .valid_out(valid_out), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; bubble = 0; freeze = 0;
        wb_en_in = 0; mem_read_in = 0; mem_write_in = 0; branch_in = 0; s_in = 0;
        alu_cmd_in = '0; pc_in = '0; val_rn_in = '0; val_rm_in = '0; imm_in = 0;
        shift_operand_in = '0; signed_imm24_in = '0;
        dest_in = '0; src1_in = '0; src2_in = '0; sr_in = '0; valid_in = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        flush = 1; bubble = 1; freeze = 1;
        wb_en_in = 1; mem_read_in = 1; mem_write_in = 1; branch_in = 1; s_in = 1;
        alu_cmd_in = '1; pc_in = '1; val_rn_in = '1; val_rm_in = '1; imm_in = 1;
        shift_operand_in = '1; signed_imm24_in = '1;
        dest_in = '1; src1_in = '1; src2_in = '1; sr_in = '1; valid_in = 1;
        rst = 1;
        tick();
        tick();
        n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        n_cmp++; if (bubble_cnt !== 3'd0) begin n_err++; $display("FAIL reset_bubble_cnt: got %0d expected 0", bubble_cnt); end
        n_cmp++; if (flush_cnt !== 3'd0) begin n_err++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
        rst = 0;
    endtask

    task automatic test_normal();
        do_reset();
        alu_cmd_in = ALU_ADD; wb_en_in = 1; pc_in = 32'h10; val_rn_in = 32'd5;
        dest_in = 4'd3; valid_in = 1;
        tick();
        n_cmp++; if (alu_cmd_out !== 4'b0010) begin n_err++; $display("FAIL normal_alu_cmd: got %h expected 2", alu_cmd_out); end
        n_cmp++; if (wb_en_out !== 1'b1) begin n_err++; $display("FAIL normal_wb_en: got %b expected 1", wb_en_out); end
        n_cmp++; if (pc_out !== 32'h10) begin n_err++; $display("FAIL normal_pc: got %h expected 10", pc_out); end
        n_cmp++; if (val_rn_out !== 32'd5) begin n_err++; $display("FAIL normal_val_rn: got %h expected 5", val_rn_out); end
        n_cmp++; if (dest_out !== 4'd3) begin n_err++; $display("FAIL normal_dest: got %h expected 3", dest_out); end
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL normal_valid: got %b expected 1", valid_out); end
    endtask

    task automatic test_freeze();
        do_reset();
        pc_in = 32'h20; valid_in = 1; wb_en_in = 1;
        tick();
        n_cmp++; if (pc_out !== 32'h20) begin n_err++; $display("FAIL freeze_load_pc: got %h expected 20", pc_out); end
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h30 + i;
            val_rn_in = 32'hA0 + i;
            flush = (i == 1);
            tick();
            n_cmp++; if (pc_out !== 32'h20) begin n_err++; $display("FAIL freeze_hold_pc[%0d]: got %h expected 20", i, pc_out); end
            n_cmp++; if (flush_cnt !== 3'd0) begin n_err++; $display("FAIL freeze_flush_cnt[%0d]: got %0d expected 0", i, flush_cnt); end
            n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL freeze_valid[%0d]: got %b expected 1", i, valid_out); end
        end
        freeze = 0; flush = 0; pc_in = 32'h44; val_rn_in = 32'h77;
        tick();
        n_cmp++; if (pc_out !== 32'h44) begin n_err++; $display("FAIL unfreeze_pc: got %h expected 44", pc_out); end
        n_cmp++; if (val_rn_out !== 32'h77) begin n_err++; $display("FAIL unfreeze_val_rn: got %h expected 77", val_rn_out); end
    endtask

    task automatic test_bubble();
        do_reset();
        valid_in = 1; mem_read_in = 1; alu_cmd_in = ALU_ADD; val_rn_in = 32'hDEADBEEF;
        bubble = 1;
        tick();
        n_cmp++; if (mem_read_out !== 1'b0) begin n_err++; $display("FAIL bubble_mem_read: got %b expected 0", mem_read_out); end
        n_cmp++; if (alu_cmd_out !== 4'd0) begin n_err++; $display("FAIL bubble_alu_cmd: got %h expected 0", alu_cmd_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL bubble_valid: got %b expected 0", valid_out); end
        n_cmp++; if (val_rn_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL bubble_val_rn: got %h expected deadbeef", val_rn_out); end
        n_cmp++; if (bubble_cnt !== 3'd1) begin n_err++; $display("FAIL bubble_cnt: got %0d expected 1", bubble_cnt); end
        bubble = 0;
        tick();
        n_cmp++; if (mem_read_out !== 1'b1) begin n_err++; $display("FAIL post_bubble_mem_read: got %b expected 1", mem_read_out); end
        n_cmp++; if (bubble_cnt !== 3'd1) begin n_err++; $display("FAIL post_bubble_cnt: got %0d expected 1", bubble_cnt); end
    endtask

    task automatic test_flush_vs_bubble();
        do_reset();
        wb_en_in = 1; mem_write_in = 1; branch_in = 1; s_in = 1; alu_cmd_in = ALU_SUB;
        pc_in = 32'h1234; val_rn_in = 32'h55; val_rm_in = 32'h66; imm_in = 1;
        shift_operand_in = 12'hABC; signed_imm24_in = 24'h123456;
        dest_in = 4'd7; src1_in = 4'd8; src2_in = 4'd9; sr_in = 4'b1010; valid_in = 1;
        flush = 1; bubble = 1;
        tick();
        n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL flush_outputs: got %h expected 0", all_out); end
        n_cmp++; if (flush_cnt !== 3'd1) begin n_err++; $display("FAIL flush_cnt_valid: got %0d expected 1", flush_cnt); end
        n_cmp++; if (bubble_cnt !== 3'd0) begin n_err++; $display("FAIL flush_bubble_cnt: got %0d expected 0", bubble_cnt); end
        valid_in = 0;
        tick();
        n_cmp++; if (flush_cnt !== 3'd1) begin n_err++; $display("FAIL flush_cnt_invalid: got %0d expected 1", flush_cnt); end
        n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL flush_outputs_invalid: got %h expected 0", all_out); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        bubble = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_cnt = (i < 7) ? CNT_W'(i + 1) : 3'd7;
            n_cmp++; if (bubble_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_bubble_cnt[%0d]: got %0d expected %0d", i, bubble_cnt, exp_cnt); end
        end
        bubble = 0;
        valid_in = 1; flush = 1;
        for (int i = 0; i < 9; i++) tick();
        n_cmp++; if (flush_cnt !== 3'd7) begin n_err++; $display("FAIL sat_flush_cnt: got %0d expected 7", flush_cnt); end
        flush = 0;
        rst = 1;
        tick();
        rst = 0;
        n_cmp++; if (bubble_cnt !== 3'd0) begin n_err++; $display("FAIL sat_reset_bubble: got %0d expected 0", bubble_cnt); end
        n_cmp++; if (flush_cnt !== 3'd0) begin n_err++; $display("FAIL sat_reset_flush: got %0d expected 0", flush_cnt); end
    endtask

    task automatic test_reset_in_freeze();
        do_reset();
        pc_in = 32'h50; valid_in = 1; bubble = 1;
        tick();
        n_cmp++; if (bubble_cnt !== 3'd1) begin n_err++; $display("FAIL rif_pre_cnt: got %0d expected 1", bubble_cnt); end
        bubble = 0; freeze = 1; rst = 1;
        tick();
        n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL rif_outputs: got %h expected 0", all_out); end
        n_cmp++; if (bubble_cnt !== 3'd0) begin n_err++; $display("FAIL rif_cnt: got %0d expected 0", bubble_cnt); end
        rst = 0; freeze = 0; pc_in = 32'h60;
        tick();
        n_cmp++; if (pc_out !== 32'h60 || valid_out !== 1'b1) begin n_err++; $display("FAIL rif_resume: got pc=%h valid=%b expected pc=60 valid=1", pc_out, valid_out); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alu_cmd_in = ALU_ORR; valid_in = 1;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'h100 + 32'(4 * i);
            val_rm_in = 32'(3 * i + 1);
            tick();
            n_cmp++; if (pc_out !== 32'h100 + 32'(4 * i)) begin n_err++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, pc_out, 32'h100 + 32'(4 * i)); end
            n_cmp++; if (val_rm_out !== 32'(3 * i + 1)) begin n_err++; $display("FAIL b2b_val_rm[%0d]: got %h expected %h", i, val_rm_out, 32'(3 * i + 1)); end
        end
        // A non-instruction must not carry control side effects into EX.
        valid_in = 0; wb_en_in = 1; mem_write_in = 1; branch_in = 1; pc_in = 32'h200;
        tick();
        n_cmp++; if ({wb_en_out, mem_write_out, branch_out, valid_out} !== 4'b0000) begin n_err++; $display("FAIL invariant_ctrl: got %b expected 0000", {wb_en_out, mem_write_out, branch_out, valid_out}); end
        n_cmp++; if (pc_out !== 32'h200) begin n_err++; $display("FAIL invariant_pc: got %h expected 200", pc_out); end
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        test_reset();
        test_normal();
        test_freeze();
        test_bubble();
        test_flush_vs_bubble();
        test_saturation();
        test_reset_in_freeze();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the decode stage (control unit, register file, operand fetch) and the execute stage.
- Captures decoded control signals and operands once per clock.
- Supports flush on taken branch, bubble insertion on data hazard, and full freeze on memory stall.
- Keeps saturating bubble and flush counters for performance monitoring.

Parameters:
- DATA_W, 32, width of PC and register operand fields
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  taken branch in EX; squash the incoming instruction
- bubble  in  1  hazard unit request; load a no-op instead of the incoming instruction
- freeze  in  1  memory stall; hold every register, counters included
- wb_en_in, mem_read_in, mem_write_in, branch_in, s_in  in  1 each  control from decode
- alu_cmd_in  in  4  execute command from decode
- pc_in  in  DATA_W  PC+4 of the instruction
- val_rn_in, val_rm_in  in  DATA_W  register operands
- imm_in  in  1  immediate-operand flag
- shift_operand_in  in  12  shifter operand field
- signed_imm24_in  in  24  branch offset
- dest_in, src1_in, src2_in  in  4 each  register indices
- sr_in  in  4  status flags NZCV at decode
- valid_in  in  1  decode stage holds a real instruction
- All of the above except clk, rst, flush, bubble and freeze have a matching *_out port of the same width (registered).
- valid_out  out  1  EX holds a real instruction
- bubble_cnt  out  CNT_W  bubbles inserted since reset
- flush_cnt  out  CNT_W  flushes since reset

Behaviour:
- Reset: on rising clk with rst=1, every output, both counters and valid_out go to 0. This is a no-op in EX.
- Priority per edge: rst > freeze > flush > bubble > normal load.
- freeze=1: all state holds, including counters. A flush or bubble asserted in the same cycle is ignored; the requester re-asserts it after the stall.
- flush=1 (no freeze): all fields load 0, valid_out=0. flush_cnt increments only if valid_in=1.
- bubble=1 (no freeze, no flush):
  - Control fields load 0: wb_en, mem_read, mem_write, branch, s, alu_cmd, valid.
  - Data fields load normally, which eases debug.
  - bubble_cnt increments unconditionally.
- flush and bubble together: flush rule applies, only flush_cnt is eligible to increment.
- Normal load: every *_out <= *_in; valid_out <= valid_in.
- Latency: exactly one cycle from *_in to *_out when no freeze is asserted.
- Counters:
  - Saturate at 2^CNT_W-1 and never wrap.
  - Cleared only by rst.
- Invariant: valid_out=0 implies wb_en_out=mem_read_out=mem_write_out=branch_out=s_out=0.
- Reset mid-freeze: rst wins; the next cycle starts from the reset values.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - ALU command constants: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
  - Mode encodings.
  - NZCV bit positions.
  - A packed decode bundle type: control plus operands.
- One sub-module: sat_counter (CNT_W, inc, hold, rst). It is instantiated twice, for bubble_cnt and flush_cnt.

Test Plan:
- Reset: drive every input to all ones, rst=1 for 2 cycles -> every output and both counters read 0, valid_out=0.
- Normal pipeline: alu_cmd_in=0010, wb_en_in=1, pc_in=0x10, val_rn_in=5, dest_in=3, valid_in=1 -> next cycle same values at outputs, valid_out=1.
- Freeze hold: load pc_in=0x20, then freeze=1 for 3 cycles while changing inputs and pulsing flush -> outputs stay pc_out=0x20 throughout, flush_cnt unchanged. Release freeze -> new inputs appear one cycle later.
- Bubble: valid instruction with mem_read_in=1, bubble=1 -> mem_read_out=0, alu_cmd_out=0, valid_out=0, val_rn_out equals input, bubble_cnt=1.
- Flush vs bubble: flush=1, bubble=1, valid_in=1 -> all outputs 0, flush_cnt=1, bubble_cnt=0. Repeat with valid_in=0 -> flush_cnt stays 1.
- Saturation: with CNT_W=3, assert bubble for 10 cycles -> bubble_cnt reaches 7 and stays 7. Then rst -> bubble_cnt=0.
